// File: rtl/seg_pkg.sv
// Shared types and limits for the multiplexed seven-segment scan controller.
package seg_pkg;

  typedef enum logic [0:0] {
    BLANK,
    SHOW
  } scan_state_t;

  localparam int unsigned SCAN_MIN_BLANK   = 2;
  localparam int unsigned SCAN_MIN_REFRESH = 2;

endpackage

// File: rtl/seg_dwell_timer.sv
// Phase dwell timer: reloads itself with load_val on the first cycle of each phase,
// and pulses tc on the last cycle, giving a phase of exactly load_val + 1 cycles.
module seg_dwell_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  // Zero marks the first cycle of a phase, so a reset count starts a fresh phase.
  always_comb begin
    count_d = count_q - WIDTH'(1);
    if (count_q == '0) begin
      count_d = load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == WIDTH'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed-display scan controller: blank/show time-sharing of one decoder across
// NUM_DIGITS common-anode digits, with frame-synchronous value swap and zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50_000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    i_clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_blank_lz,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [3:0]              o_digit_bin,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);

  localparam int unsigned IW     = $clog2(NUM_DIGITS);
  localparam int unsigned MAXLEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned DW     = $clog2(MAXLEN);
  localparam int unsigned VW     = 4 * NUM_DIGITS;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be 2..8");
  end
  if (REFRESH_DIV < SCAN_MIN_REFRESH) begin : g_bad_refresh
    $error("seg_scan_ctrl: REFRESH_DIV too small");
  end
  if (BLANK_CYCLES < SCAN_MIN_BLANK) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES too small");
  end

  scan_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] act_val_q, act_val_d;
  logic          act_lz_q, act_lz_d;
  logic [VW-1:0] pend_val_q, pend_val_d;
  logic          pend_lz_q, pend_lz_d;
  logic          pend_full_q, pend_full_d;
  logic [3:0]    bin_q, bin_d;
  logic          fd_q, fd_d;

  logic          tc;
  logic [DW-1:0] load_val;
  logic          accept;
  logic          wrap;
  logic          upper_zero;
  logic          suppress;

  assign load_val = (state_q == BLANK) ? DW'(BLANK_CYCLES - 1) : DW'(REFRESH_DIV - 1);

  seg_dwell_timer #(
    .WIDTH (DW)
  ) u_dwell (
    .clk      (i_clk),
    .rst_n    (rst_n),
    .load_val (load_val),
    .tc       (tc)
  );

  assign accept = i_valid && !pend_full_q;
  assign wrap   = (idx_q == IW'(NUM_DIGITS - 1));

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      act_val_q   <= '0;
      act_lz_q    <= 1'b0;
      pend_val_q  <= '0;
      pend_lz_q   <= 1'b0;
      pend_full_q <= 1'b0;
      bin_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_lz_q    <= act_lz_d;
      pend_val_q  <= pend_val_d;
      pend_lz_q   <= pend_lz_d;
      pend_full_q <= pend_full_d;
      bin_q       <= bin_d;
      fd_q        <= fd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_val_d   = act_val_q;
    act_lz_d    = act_lz_q;
    pend_val_d  = pend_val_q;
    pend_lz_d   = pend_lz_q;
    pend_full_d = pend_full_q;
    bin_d       = bin_q;
    fd_d        = 1'b0;
    if (accept) begin
      pend_val_d  = i_value;
      pend_lz_d   = i_blank_lz;
      pend_full_d = 1'b1;
    end
    unique case (state_q)
      BLANK: begin
        if (tc) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (tc) begin
          state_d = BLANK;
          idx_d   = wrap ? '0 : idx_q + IW'(1);
          if (wrap) begin
            fd_d = 1'b1;
            if (pend_full_q) begin
              act_val_d   = pend_val_q;
              act_lz_d    = pend_lz_q;
              pend_full_d = 1'b0;
            end
          end
          // Nibble is latched on blank entry so the decoder settles before the enable rises.
          bin_d = act_val_d[{idx_d, 2'b00} +: 4];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_q) && act_val_q[4*k +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign suppress = act_lz_q && (idx_q != '0) && upper_zero;

  always_comb begin
    o_digit_en = '0;
    if (state_q == SHOW && !suppress) begin
      o_digit_en[idx_q] = 1'b1;
    end
  end

  assign o_ready      = !pend_full_q;
  assign o_digit_bin  = bin_q;
  assign o_frame_done = fd_q;

endmodule
